// File: rtl/dense_argmax_classifier.sv
// dense_argmax_classifier: latches a signed score vector, scans it one entry per cycle for the
// maximum (lowest index wins ties) and presents index, score and threshold hit through a valid/ready handshake.
module dense_argmax_classifier #(
    parameter int                N_CLASSES = 8,
    parameter logic signed [7:0] MIN_SCORE = 8'sd16,
    parameter int                IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [7:0]    scores [0:N_CLASSES-1],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     class_idx,
    output logic signed [7:0]    class_score,
    output logic                 class_detected,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            r_state, w_next;
    logic signed [7:0] r_buf [0:N_CLASSES-1];
    logic signed [7:0] r_best, r_class_score, w_cand, w_max;
    logic [IDX_W-1:0]  r_best_idx, r_cnt, r_class_idx, w_max_idx;
    logic              r_class_detected, w_accept, w_gt, w_last;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_cand    = r_buf[r_cnt];
    assign w_gt      = w_cand > r_best;
    assign w_max     = w_gt ? w_cand : r_best;
    assign w_max_idx = w_gt ? r_cnt : r_best_idx;
    assign w_last    = r_cnt == IDX_W'(N_CLASSES - 1);

    assign in_ready       = (r_state == IDLE) && !rst;
    assign out_valid      = r_state == DONE;
    assign busy           = r_state != IDLE;
    assign class_idx      = r_class_idx;
    assign class_score    = r_class_score;
    assign class_detected = r_class_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (in_valid ? ((N_CLASSES == 1) ? DONE : SCAN) : IDLE) :
                 (r_state == SCAN) ? (w_last ? DONE : SCAN) :
                 (r_state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end

    // Buffer is deliberately not reset; it is fully overwritten on every accept.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf <= scores;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best           <= '0;
            r_best_idx       <= '0;
            r_cnt            <= '0;
            r_class_idx      <= '0;
            r_class_score    <= '0;
            r_class_detected <= 1'b0;
        end else if (w_accept) begin
            r_best     <= scores[0];
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
            if (N_CLASSES == 1) begin
                r_class_idx      <= '0;
                r_class_score    <= scores[0];
                r_class_detected <= scores[0] >= MIN_SCORE;
            end
        end else if (r_state == SCAN) begin
            r_cnt      <= r_cnt + 1'b1;
            r_best     <= w_max;
            r_best_idx <= w_max_idx;
            if (w_last) begin
                r_class_idx      <= w_max_idx;
                r_class_score    <= w_max;
                r_class_detected <= w_max >= MIN_SCORE;
            end
        end
    end
endmodule

// File: tb/tb_dense_argmax_classifier.sv
// tb_dense_argmax_classifier: randomized and directed checks of the argmax classifier
// against a plain first-maximum search model.
module tb_dense_argmax_classifier;
    localparam int                N   = 8;
    localparam int                IW  = 3;
    localparam logic signed [7:0] MIN = 8'sd16;

    typedef logic signed [7:0] vec_t [0:N-1];

    logic              clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    vec_t              scores;
    logic              in_ready, out_valid, class_detected, busy;
    logic [IW-1:0]     class_idx;
    logic signed [7:0] class_score;
    int                n_checks = 0, n_pass = 0;

    dense_argmax_classifier #(.N_CLASSES(N), .MIN_SCORE(MIN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
        .class_score(class_score), .class_detected(class_detected), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model(input vec_t v, output int idx, output logic signed [7:0] sc, output logic det);
        idx = 0;
        sc  = v[0];
        for (int i = 1; i < N; i++)
            if (v[i] > sc) begin
                sc  = v[i];
                idx = i;
            end
        det = sc >= MIN;
    endfunction

    function automatic vec_t rand_vec(input int mode);
        vec_t r;
        foreach (r[i]) r[i] = (mode == 0) ? 8'($urandom) : 8'($signed($urandom_range(0, 6)) - 3);
        return r;
    endfunction

    // Drives one vector, counts rising edges from the accepting edge (inclusive) until out_valid.
    task automatic classify(input vec_t v, input bit scramble, output int lat);
        @(negedge clk);
        scores   = v;
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (scramble) scores = rand_vec(0);
        end while (!out_valid && lat < 300);
        if (lat >= 300) $display("FAIL classify timeout: out_valid never rose");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({class_idx, class_score, class_detected} !== '0)
            $display("FAIL reset result: got idx=%0d score=%0d det=%b want zeros", class_idx, class_score, class_detected); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset release in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_vector(input string nm, input vec_t v, input bit scramble);
        int lat, e_idx;
        logic signed [7:0] e_sc;
        logic e_det;
        model(v, e_idx, e_sc, e_det);
        out_ready = 1'b1;
        classify(v, scramble, lat);
        n_checks++; if (lat !== N) $display("FAIL %s latency: got %0d want %0d", nm, lat, N); else n_pass++;
        n_checks++; if (class_idx !== e_idx[IW-1:0]) $display("FAIL %s idx: got %0d want %0d", nm, class_idx, e_idx); else n_pass++;
        n_checks++; if (class_score !== e_sc) $display("FAIL %s score: got %0d want %0d", nm, class_score, e_sc); else n_pass++;
        n_checks++; if (class_detected !== e_det) $display("FAIL %s detected: got %b want %b", nm, class_detected, e_det); else n_pass++;
        @(negedge clk);
        n_checks++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL %s pulse: got out_valid=%b in_ready=%b want 0,1", nm, out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_spec_vector();
        vec_t v;
        v = '{3, 9, -5, 40, 12, 40, 0, 7};
        test_vector("spec", v, 1'b0);
    endtask

    task automatic test_boundaries();
        vec_t tbl [5];
        tbl[0] = '{-128, -128, -128, -128, -128, -128, -128, -128};
        tbl[1] = '{5, 5, 5, 5, 5, 5, 5, 5};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 100};
        tbl[3] = '{100, 0, -1, 99, 100, -128, 127, 127};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3][6] = 8'sd50;
        tbl[3][7] = 8'sd16;
        foreach (tbl[i]) test_vector($sformatf("boundary%0d", i), tbl[i], 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) test_vector($sformatf("random%0d", i), rand_vec(i % 2), 1'b0);
    endtask

    task automatic test_scramble();
        for (int i = 0; i < 4; i++) test_vector($sformatf("scramble%0d", i), rand_vec(0), 1'b1);
    endtask

    task automatic test_backpressure();
        int lat, e_idx;
        logic signed [7:0] e_sc;
        logic e_det;
        vec_t v;
        v = rand_vec(0);
        model(v, e_idx, e_sc, e_det);
        out_ready = 1'b0;
        classify(v, 1'b0, lat);
        n_checks++; if (lat !== N) $display("FAIL bp latency: got %0d want %0d", lat, N); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if ({out_valid, in_ready, busy} !== 3'b101)
                $display("FAIL bp hold%0d flags: got ov=%b ir=%b busy=%b want 1,0,1", c, out_valid, in_ready, busy); else n_pass++;
            n_checks++; if ({class_idx, class_score, class_detected} !== {e_idx[IW-1:0], e_sc, e_det})
                $display("FAIL bp hold%0d result: got idx=%0d score=%0d want idx=%0d score=%0d", c, class_idx, class_score, e_idx, e_sc); else n_pass++;
            in_valid = (c == 2);
            scores   = rand_vec(0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp release: got out_valid=%b in_ready=%b want 0,1", out_valid, in_ready); else n_pass++;
        n_checks++; if ({class_idx, class_score, class_detected} !== {e_idx[IW-1:0], e_sc, e_det})
            $display("FAIL bp retain: got idx=%0d score=%0d want idx=%0d score=%0d", class_idx, class_score, e_idx, e_sc); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int seen = 0;
        vec_t v;
        @(negedge clk);
        scores    = rand_vec(0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL midscan busy: got %b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, in_ready, busy, class_idx, class_score, class_detected} !== '0)
            $display("FAIL midscan async reset: got ov=%b ir=%b busy=%b idx=%0d score=%0d det=%b want zeros",
                     out_valid, in_ready, busy, class_idx, class_score, class_detected); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL midscan stray out_valid: got %0d cycles want 0", seen); else n_pass++;
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        test_vector("after_reset", v, 1'b0);
    endtask

    initial begin
        scores = '{default: 8'sd0};
        test_reset();
        test_spec_vector();
        test_boundaries();
        test_random();
        test_scramble();
        test_backpressure();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dense_argmax_classifier.md
DENSE_ARGMAX_CLASSIFIER -- requirements
Module: dense_argmax_classifier

Interface
REQ-001 The block SHALL have parameter N_CLASSES, default 8, giving the number of signed score inputs (legal range 1..256).
REQ-002 The block SHALL have parameter MIN_SCORE, default 8'sd16, giving the signed detection threshold.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(N_CLASSES) with a minimum of 1, giving the class index width.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  is the reset: asynchronous, active-high.
REQ-006 Port in_valid  input  1  marks the scores vector as valid.
REQ-007 Port in_ready  output  1  means the block can accept a vector.
REQ-008 Port scores  input  signed 8 x [0:N_CLASSES-1]  carries the dense-layer output vector.
REQ-009 Port out_valid  output  1  marks the result as valid.
REQ-010 Port out_ready  input  1  means downstream accepts the result.
REQ-011 Port class_idx  output  IDX_W  is the index of the maximum score.
REQ-012 Port class_score  output  signed 8  is the maximum score value.
REQ-013 Port class_detected  output  1  is high when class_score >= MIN_SCORE (signed compare).
REQ-014 Port busy  output  1  is high in SCAN or DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: on a clk edge in IDLE with in_valid=1, the block SHALL latch all scores into an internal buffer, load best_score=scores[0], best_idx=0 and cnt=1, and go to SCAN (or directly to DONE if N_CLASSES=1).
REQ-018 Changes on scores after acceptance SHALL NOT affect the result.
REQ-019 SCAN: each cycle the block SHALL compare buf[cnt] against best_score (signed 8-bit) and replace best_score/best_idx only on strictly greater, so ties keep the lowest index.
REQ-020 SCAN: the block SHALL increment cnt each cycle, and after comparing cnt=N_CLASSES-1 go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly N_CLASSES clk edges after the accepting edge (1 edge if N_CLASSES=1).
REQ-022 class_idx, class_score and class_detected SHALL be registered, updated only on entry to DONE, and held stable while out_valid=1 and out_ready=0.
REQ-023 DONE: out_valid and out_ready both high on an edge SHALL complete the transfer and return the FSM to IDLE; the result outputs SHALL retain their values.
REQ-024 in_valid in SCAN/DONE SHALL be ignored (in_ready=0); no overlap or queueing is provided.
REQ-025 out_ready while not in DONE SHALL have no effect.
REQ-026 An all-zero vector SHALL yield class_idx=0, class_score=0 and class_detected=(0>=MIN_SCORE).
REQ-027 Scores equal to -128 SHALL be handled without overflow; no arithmetic beyond comparison is performed.

Reset
REQ-028 While rst=1 the block SHALL force: state=IDLE, in_ready=0, out_valid=0, busy=0, class_idx=0, class_score=0, class_detected=0, cnt=0.
REQ-029 Reset asserted during SCAN or DONE SHALL abort the classification immediately, with no out_valid pulse after release.
REQ-030 On the first clk edge after rst deasserts the block SHALL be in IDLE with in_ready=1; the buffer contents need not be reset.

Verification
REQ-031 N=8, MIN=16, scores={3,9,-5,40,12,40,0,7}, out_ready=1 -> out_valid exactly 8 edges after accept, class_idx=3 (tie resolved to the lower index), class_score=40, detected=1, one-cycle out_valid pulse.
REQ-032 scores={-128 x8} -> class_idx=0, class_score=-128, detected=0; with all scores = 5 -> class_idx=0, score=5, detected=0.
REQ-033 Max at the last index, {0,0,0,0,0,0,0,100} -> class_idx=7, score=100; max at index 0 -> class_idx=0.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stay constant, in_ready=0, and an in_valid pulse is ignored; after out_ready=1 one edge later -> IDLE, in_ready=1.
REQ-035 scores changed each cycle during SCAN -> the result matches the vector present at the accepting edge only.
REQ-036 rst pulsed at scan cycle 4 -> all outputs go to 0 asynchronously, no out_valid follows, and a new vector {1,2,3,4,5,6,7,8} afterwards -> class_idx=7, score=8, detected=0.
